elastic_join: RTL

ELASTIC_JOIN -- requirements
Module: elastic_join

---
 rtl/elastic_join.sv | 92 +++++++++
 1 files changed

// File: rtl/elastic_join.sv
// elastic_join: joins NEIGHBOR_PE_NUM elastic input lanes into one operand set.
// Each lane has a 2-entry FIFO so a producer can run one word ahead of the
// slowest enabled lane. A set fires when every enabled lane holds a word and
// the consumer is not stalling. Lanes are enabled by the available_input mask.
module elastic_join #(
  parameter int DATA_WIDTH      = 32,
  parameter int NEIGHBOR_PE_NUM = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      input_data [NEIGHBOR_PE_NUM],
  input  logic [NEIGHBOR_PE_NUM-1:0] valid_input,
  output logic [NEIGHBOR_PE_NUM-1:0] stop_input,
  output logic [DATA_WIDTH-1:0]      output_data [NEIGHBOR_PE_NUM],
  output logic                       valid_output,
  input  logic                       stop_output,
  input  logic [NEIGHBOR_PE_NUM-1:0] available_input
);

  localparam int N = NEIGHBOR_PE_NUM;

  // Per-lane 2-entry buffer state.
  logic [DATA_WIDTH-1:0] mem   [N][2];
  logic                  head  [N];
  logic [1:0]            count [N];

  logic [N-1:0] push;
  logic [N-1:0] pop;
  logic [N-1:0] lane_ready;
  logic         fire;

  // Per-lane handshake decode and head-entry presentation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves a value held and a latch is inferred.
    stop_input = '0;
    push       = '0;
    lane_ready = '0;
    for (int i = 0; i < N; i++) begin
      output_data[i] = '0;
      // Backpressure depends only on registered count and the static mask,
      // never on stop_output, which keeps long combinational paths out.
      stop_input[i] = available_input[i] & (count[i] == 2'd2);
      push[i]       = valid_input[i] & available_input[i] & ~stop_input[i];
      // A disabled lane never holds the join back.
      lane_ready[i] = ~available_input[i] | (count[i] != 2'd0);
      if (available_input[i]) begin
        output_data[i] = mem[i][head[i]];
      end
    end
  end

  // Join condition: at least one lane enabled and all enabled lanes hold data.
  always_comb begin
    valid_output = (|available_input) & (&lane_ready);
    fire         = valid_output & ~stop_output;
    pop          = fire ? available_input : '0;
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic tail;
    // Next free slot: head when empty, the other slot when one word is held.
    assign tail = head[g] ^ count[g][0];

    // Lane FIFO update: write at tail on push, advance head on pop.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        // NOTE: storage is cleared on reset so output_data reads zero from
        // the first cycle; a plain RAM would be left unreset instead.
        mem[g][0] <= '0;
        mem[g][1] <= '0;
        head[g]   <= 1'b0;
        count[g]  <= 2'd0;
      end else begin
        // NOTE: non-blocking assignments here, so every register samples the
        // pre-edge values no matter the order of the statements.
        if (push[g]) begin
          mem[g][tail] <= input_data[g];
        end
        if (pop[g]) begin
          head[g] <= ~head[g];
        end
        case ({push[g], pop[g]})
          2'b10:   count[g] <= count[g] + 2'd1;
          2'b01:   count[g] <= count[g] - 2'd1;
          default: count[g] <= count[g];
        endcase
      end
    end
  end

endmodule
